// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity codes, rx FSM states
// and the minimum legal frame length.
package uart_pkg;

    localparam int UART_MIN_DATA_BITS = 5;

    localparam logic [1:0] UART_PAR_NONE = 2'd0;
    localparam logic [1:0] UART_PAR_ODD  = 2'd1;
    localparam logic [1:0] UART_PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2
    } rx_state_e;

endpackage

// File: rtl/uart_sync_bit.sv
// Multi-flop synchroniser for one asynchronous input; flops reset to 1 so an idle-high
// line never looks like a start bit coming out of reset.
module uart_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver, one per channel, with a valid/ready word output.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote around every bit centre.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RX_IDLE   | waiting for synced rx low while cfg_enable is set
// RX_START  | confirming the start bit at its centre (false start -> IDLE)
// RX_DATA   | collecting bits_q data bits into the shift register
// RX_PARITY | checking the parity bit against the running ones count
// RX_STOP1  | first stop bit; low sample flags a framing error
// RX_STOP2  | second stop bit when the frame uses two
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_os,
    input  logic              uart_rx,
    input  logic              cfg_enable,
    input  logic [3:0]        cfg_data_bits,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic              cfg_lsb_first,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_err_parity,
    output logic              m_err_frame,
    output logic              m_err_overrun,
    output logic              busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_END = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0] DW4  = 4'(DATA_W);
    localparam logic [3:0] MIN4 = 4'(UART_MIN_DATA_BITS);

    logic rx_s;

    uart_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rx),
        .q_o (rx_s)
    );

    rx_state_e         state_q, state_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        bits_q, bits_d;
    logic [1:0]        par_q, par_d;
    logic              stop2_q, stop2_d;
    logic              lsb_q, lsb_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ones_q, ones_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_err_parity_q, m_err_parity_d;
    logic              m_err_frame_q, m_err_frame_d;
    logic              m_err_overrun_q, m_err_overrun_d;

`ifdef UART_RX_MAJORITY_EN
    logic maj_a_q, maj_a_d;
    logic maj_b_q, maj_b_d;
    logic pend_q, pend_d;
`endif

    logic [OS_W-1:0] centre;
    logic            bit_evt;
    logic            bit_dec;
    logic [3:0]      bits_eff;
    logic            par_en;
    logic [3:0]      data_idx;

    always_comb begin
        state_d         = state_q;
        os_cnt_d        = os_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        bits_d          = bits_q;
        par_d           = par_q;
        stop2_d         = stop2_q;
        lsb_d           = lsb_q;
        shift_d         = shift_q;
        ones_d          = ones_q;
        perr_d          = perr_q;
        ferr_d          = ferr_q;
        done_d          = 1'b0;
        m_data_d        = m_data_q;
        m_valid_d       = m_valid_q;
        m_err_parity_d  = m_err_parity_q;
        m_err_frame_d   = m_err_frame_q;
        m_err_overrun_d = m_err_overrun_q;

        centre   = (state_q == RX_START) ? OS_MID : OS_END;
        bits_eff = (cfg_data_bits < MIN4 || cfg_data_bits > DW4) ? DW4 : cfg_data_bits;
        par_en   = !(par_q == UART_PAR_NONE || par_q == 2'd3);
        data_idx = lsb_q ? bit_cnt_q : (bits_q - 4'd1 - bit_cnt_q);

        // Counter wraps at the centre so the bit period stays OVERSAMPLE ticks in both builds.
        if (state_q != RX_IDLE && ce_os) begin
            os_cnt_d = (os_cnt_q == centre) ? '0 : os_cnt_q + 1'b1;
        end

`ifdef UART_RX_MAJORITY_EN
        maj_a_d = maj_a_q;
        maj_b_d = maj_b_q;
        pend_d  = pend_q;
        // Votes at centre-1 and centre are held; the decision lands on the following tick.
        if (state_q != RX_IDLE && ce_os) begin
            if (os_cnt_q == centre - 1'b1) maj_a_d = rx_s;
            if (os_cnt_q == centre) begin
                maj_b_d = rx_s;
                pend_d  = 1'b1;
            end
            if (pend_q) pend_d = 1'b0;
        end
        bit_evt = ce_os && pend_q;
        bit_dec = (maj_a_q & maj_b_q) | (maj_a_q & rx_s) | (maj_b_q & rx_s);
`else
        bit_evt = ce_os && (state_q != RX_IDLE) && (os_cnt_q == centre);
        bit_dec = rx_s;
`endif

        case (state_q)
            RX_IDLE: begin
                if (!rx_s && cfg_enable) begin
                    state_d   = RX_START;
                    os_cnt_d  = '0;
                    bits_d    = bits_eff;
                    par_d     = cfg_parity;
                    stop2_d   = cfg_stop2;
                    lsb_d     = cfg_lsb_first;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    ones_d    = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
`ifdef UART_RX_MAJORITY_EN
                    pend_d    = 1'b0;
`endif
                end
            end
            RX_START: begin
                if (bit_evt) begin
                    state_d = bit_dec ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_evt) begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (data_idx == 4'(i)) shift_d[i] = bit_dec;
                    end
                    ones_d    = ones_q ^ bit_dec;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == bits_q - 4'd1) begin
                        state_d = par_en ? RX_PARITY : RX_STOP1;
                    end
                end
            end
            RX_PARITY: begin
                if (bit_evt) begin
                    perr_d  = (par_q == UART_PAR_ODD) ? !(ones_q ^ bit_dec) : (ones_q ^ bit_dec);
                    state_d = RX_STOP1;
                end
            end
            RX_STOP1: begin
                if (bit_evt) begin
                    if (!bit_dec) ferr_d = 1'b1;
                    if (stop2_q) begin
                        state_d = RX_STOP2;
                    end else begin
                        state_d = RX_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            RX_STOP2: begin
                if (bit_evt) begin
                    if (!bit_dec) ferr_d = 1'b1;
                    state_d = RX_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // A finished frame only replaces the held word if the consumer is taking it now.
        if (done_q) begin
            if (!m_valid_q || m_ready) begin
                m_data_d        = shift_q;
                m_err_parity_d  = perr_q;
                m_err_frame_d   = ferr_q;
                m_err_overrun_d = 1'b0;
                m_valid_d       = 1'b1;
            end else begin
                m_err_overrun_d = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RX_IDLE;
            os_cnt_q        <= '0;
            bit_cnt_q       <= '0;
            bits_q          <= '0;
            par_q           <= '0;
            stop2_q         <= 1'b0;
            lsb_q           <= 1'b0;
            shift_q         <= '0;
            ones_q          <= 1'b0;
            perr_q          <= 1'b0;
            ferr_q          <= 1'b0;
            done_q          <= 1'b0;
            m_data_q        <= '0;
            m_valid_q       <= 1'b0;
            m_err_parity_q  <= 1'b0;
            m_err_frame_q   <= 1'b0;
            m_err_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            os_cnt_q        <= os_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            bits_q          <= bits_d;
            par_q           <= par_d;
            stop2_q         <= stop2_d;
            lsb_q           <= lsb_d;
            shift_q         <= shift_d;
            ones_q          <= ones_d;
            perr_q          <= perr_d;
            ferr_q          <= ferr_d;
            done_q          <= done_d;
            m_data_q        <= m_data_d;
            m_valid_q       <= m_valid_d;
            m_err_parity_q  <= m_err_parity_d;
            m_err_frame_q   <= m_err_frame_d;
            m_err_overrun_q <= m_err_overrun_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
            pend_q  <= 1'b0;
        end else begin
            maj_a_q <= maj_a_d;
            maj_b_q <= maj_b_d;
            pend_q  <= pend_d;
        end
    end
`endif

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_err_parity  = m_err_parity_q;
    assign m_err_frame   = m_err_frame_q;
    assign m_err_overrun = m_err_overrun_q;
    assign busy          = (state_q != RX_IDLE);

endmodule
